// File: rtl/fp_unpack_align_stage.sv
// Front stage of the FPU: unpacks and classifies both operands, orders them by
// magnitude, computes alignment shift and mul/div exponent, then queues results in a 2-entry skid buffer.
module fp_unpack_align_stage #(
    parameter int ExponentSize = 8,
    parameter int FractionSize = 23,
    localparam int DataSize     = ExponentSize + FractionSize + 1,
    localparam int MantissaSize = FractionSize + 1,
    localparam int ShiftSize    = $clog2(MantissaSize + 3),
    localparam int Bias         = 2 ** (ExponentSize - 1) - 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [DataSize-1:0]       Operand1,
    input  logic [DataSize-1:0]       Operand2,
    input  logic [1:0]                Operation,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [1:0]                OutOperation,
    output logic                      OutEffSub,
    output logic                      OutSwap,
    output logic                      OutSignBig,
    output logic [ExponentSize-1:0]   OutBigExp,
    output logic [MantissaSize-1:0]   OutBigMant,
    output logic [MantissaSize-1:0]   OutSmallMant,
    output logic [ShiftSize-1:0]      OutShift,
    output logic                      OutExpEqual,
    output logic [ExponentSize+1:0]   OutMDExp,
    output logic                      OutNaN,
    output logic                      OutInf,
    output logic                      OutZeroA,
    output logic                      OutZeroB
);

    localparam logic [ExponentSize-1:0] ShiftSatE  = ExponentSize'(MantissaSize + 2);
    localparam logic [ShiftSize-1:0]    ShiftSatS  = ShiftSize'(MantissaSize + 2);
    localparam logic [ExponentSize+1:0] BiasX      = (ExponentSize + 2)'(Bias);

    typedef struct packed {
        logic [1:0]              op;
        logic                    eff_sub;
        logic                    swap;
        logic                    sign_big;
        logic [ExponentSize-1:0] big_exp;
        logic [MantissaSize-1:0] big_mant;
        logic [MantissaSize-1:0] small_mant;
        logic [ShiftSize-1:0]    shift;
        logic                    exp_equal;
        logic [ExponentSize+1:0] md_exp;
        logic                    nan;
        logic                    inf;
        logic                    zero_a;
        logic                    zero_b;
    } entry_t;

    logic                    sign_a, sign_b;
    logic [ExponentSize-1:0] exp_a, exp_b, eff_a, eff_b, exp_small, diff;
    logic [FractionSize-1:0] frac_a, frac_b;
    logic [MantissaSize-1:0] mant_a, mant_b;
    logic                    zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic                    is_mul, is_div;
    entry_t                  new_e;

    assign {sign_a, exp_a, frac_a} = Operand1;
    assign {sign_b, exp_b, frac_b} = Operand2;

    always_comb begin
        zero_a = (exp_a == '0) && (frac_a == '0);
        zero_b = (exp_b == '0) && (frac_b == '0);
        inf_a  = (exp_a == '1) && (frac_a == '0);
        inf_b  = (exp_b == '1) && (frac_b == '0);
        nan_a  = (exp_a == '1) && (frac_a != '0);
        nan_b  = (exp_b == '1) && (frac_b != '0);
        // Zero and subnormal share exponent 1 so they order correctly against normals.
        eff_a  = (exp_a == '0) ? ExponentSize'(1) : exp_a;
        eff_b  = (exp_b == '0) ? ExponentSize'(1) : exp_b;
        mant_a = {exp_a != '0, frac_a};
        mant_b = {exp_b != '0, frac_b};
        is_mul = (Operation == 2'b10);
        is_div = (Operation == 2'b11);

        new_e          = '0;
        new_e.op       = Operation;
        new_e.eff_sub  = ~Operation[1] & (Operation[0] ^ sign_a ^ sign_b);
        new_e.swap     = {eff_b, mant_b} > {eff_a, mant_a};
        new_e.zero_a   = zero_a;
        new_e.zero_b   = zero_b;
        if (new_e.swap) begin
            new_e.sign_big   = sign_b ^ (Operation[0] & ~Operation[1]);
            new_e.big_exp    = eff_b;
            new_e.big_mant   = mant_b;
            new_e.small_mant = mant_a;
            exp_small        = eff_a;
        end else begin
            new_e.sign_big   = sign_a;
            new_e.big_exp    = eff_a;
            new_e.big_mant   = mant_a;
            new_e.small_mant = mant_b;
            exp_small        = eff_b;
        end
        diff            = new_e.big_exp - exp_small;
        new_e.shift     = (diff > ShiftSatE) ? ShiftSatS : diff[ShiftSize-1:0];
        new_e.exp_equal = (diff == '0);

        if (is_mul)
            new_e.md_exp = {2'b00, eff_a} + {2'b00, eff_b} - BiasX;
        else if (is_div)
            new_e.md_exp = {2'b00, eff_a} - {2'b00, eff_b} + BiasX;

        new_e.nan = nan_a | nan_b
                  | (~Operation[1] & inf_a & inf_b & new_e.eff_sub)
                  | (is_mul & ((zero_a & inf_b) | (inf_a & zero_b)))
                  | (is_div & ((zero_a & zero_b) | (inf_a & inf_b)));
        new_e.inf = ~new_e.nan
                  & ((~Operation[1] & (inf_a | inf_b))
                  |  (is_mul & (inf_a | inf_b))
                  |  (is_div & (inf_a | (zero_b & ~zero_a))));
    end

    // Handshake: a beat moves on a rising edge when valid and ready are both high;
    // InReady depends only on registered occupancy, never on OutReady.
    entry_t     head_q, head_d, tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, out_valid_q;
    logic       push, pop;

    always_comb begin
        push    = InValid & in_ready_q;
        pop     = out_valid_q & OutReady;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = new_e;
                else                 tail_d = new_e;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) head_d = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable at count 1: the new entry becomes the head directly.
                head_d = new_e;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            in_ready_q  <= (count_d != 2'd2);
            out_valid_q <= (count_d != 2'd0);
        end
    end

    assign InReady      = in_ready_q;
    assign OutValid     = out_valid_q;
    assign OutOperation = head_q.op;
    assign OutEffSub    = head_q.eff_sub;
    assign OutSwap      = head_q.swap;
    assign OutSignBig   = head_q.sign_big;
    assign OutBigExp    = head_q.big_exp;
    assign OutBigMant   = head_q.big_mant;
    assign OutSmallMant = head_q.small_mant;
    assign OutShift     = head_q.shift;
    assign OutExpEqual  = head_q.exp_equal;
    assign OutMDExp     = head_q.md_exp;
    assign OutNaN       = head_q.nan;
    assign OutInf       = head_q.inf;
    assign OutZeroA     = head_q.zero_a;
    assign OutZeroB     = head_q.zero_b;

endmodule
